// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
package pc_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      TRAP = 3'd4
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          DEFAULT_PC_STEP  = 32'd4;

   function automatic logic low_bits_set(input logic [1:0] addr_lsbs);
      return (addr_lsbs != 2'b00);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset, load enable, optional forcing of the
// two address LSBs to zero on load.
module pc_reg #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter bit               MASK_LOW = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   logic [XLEN-1:0] load_value;
   logic [XLEN-1:0] q_r;

   assign load_value = MASK_LOW ? {d[XLEN-1:2], 2'b00} : d;
   assign q          = q_r;

   // PC storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r <= RESET_PC;
      end else if (load) begin
         q_r <= load_value;
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, instruction-memory request/response handshake and
// decode hand-off. Define PC_FETCH_MISALIGN_TRAP_EN to trap on misaligned targets.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
   parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_next_i,
   input  logic            redirect_i,
   input  logic            stall_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   output logic            misalign_o,
`endif
   input  logic            dec_ready_i
);

   fetch_state_t    state_r, state_n;
   logic            req_r, req_n;
   logic            kill_r, kill_n;
   logic            valid_r, valid_n;
   logic [XLEN-1:0] instr_r, instr_n;
   logic [XLEN-1:0] instr_pc_r, instr_pc_n;
   logic [XLEN-1:0] pc;
   logic            pc_load;
   logic            handshake;

   assign handshake = req_r & imem_ready_i;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      .MASK_LOW (1'b0)
`else
      .MASK_LOW (1'b1)
`endif
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .load  (pc_load),
      .d     (pc_next_i),
      .q     (pc)
   );

   assign pc_o          = pc;
   assign imem_addr_o   = pc;
   assign pc_plus_o     = pc + XLEN'(PC_STEP);
   assign imem_req_o    = req_r;
   assign instr_valid_o = valid_r;
   assign instr_o       = instr_r;
   assign instr_pc_o    = instr_pc_r;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   assign misalign_o    = (state_r == TRAP);
`endif

   // FSM state, request flag, squash flag and decode hold registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         req_r      <= 1'b0;
         kill_r     <= 1'b0;
         valid_r    <= 1'b0;
         instr_r    <= XLEN'(NOP_INSTR);
         instr_pc_r <= RESET_PC;
      end else begin
         state_r    <= state_n;
         req_r      <= req_n;
         kill_r     <= kill_n;
         valid_r    <= valid_n;
         instr_r    <= instr_n;
         instr_pc_r <= instr_pc_n;
      end
   end

   // Next-state, handshake and PC-load decisions; redirect outranks normal flow.
   always_comb begin
      state_n    = state_r;
      req_n      = req_r;
      kill_n     = kill_r;
      valid_n    = valid_r;
      instr_n    = instr_r;
      instr_pc_n = instr_pc_r;
      pc_load    = 1'b0;
      case (state_r)
         IDLE: begin
            pc_load = redirect_i;
            if (!stall_i) begin
               state_n = REQ;
               req_n   = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         REQ: begin
            if (handshake) begin
               state_n = WAIT;
               req_n   = 1'b0;
               pc_load = redirect_i;
               kill_n  = redirect_i;
            end else if (redirect_i) begin
               // Request goes low for a cycle so its address never moves while valid.
               pc_load = 1'b1;
               req_n   = 1'b0;
            end else begin
               req_n   = req_r | ~stall_i;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               kill_n = 1'b0;
               if (redirect_i || kill_r) begin
                  pc_load = redirect_i;
                  state_n = REQ;
                  req_n   = ~stall_i;
               end else begin
                  instr_n    = imem_rdata_i;
                  instr_pc_n = pc;
                  valid_n    = 1'b1;
                  state_n    = HOLD;
               end
            end else begin
               pc_load = redirect_i;
               kill_n  = kill_r | redirect_i;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               pc_load = 1'b1;
               valid_n = 1'b0;
               state_n = REQ;
               req_n   = ~stall_i;
            end else if (dec_ready_i && !stall_i) begin
               pc_load = 1'b1;
               valid_n = 1'b0;
               state_n = REQ;
               req_n   = 1'b1;
            end else begin
               valid_n = 1'b1;
            end
         end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
         TRAP: begin
            pc_load = redirect_i;
            if (redirect_i && !low_bits_set(pc_next_i[1:0])) begin
               state_n = REQ;
               req_n   = ~stall_i;
            end else begin
               state_n = TRAP;
               req_n   = 1'b0;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
            kill_n  = 1'b0;
            valid_n = 1'b0;
         end
      endcase
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      // Any load of a misaligned target parks the unit, whatever state it came from.
      if (pc_load && low_bits_set(pc_next_i[1:0])) begin
         state_n = TRAP;
         req_n   = 1'b0;
         kill_n  = 1'b0;
         valid_n = 1'b0;
      end else begin
         state_n = state_n;
      end
`endif
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_WAIT = 2;
   localparam int PH_HOLD = 3;
   localparam int PH_TRAP = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_next_i;
   logic        redirect_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        dec_ready_i;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] m_pc, m_instr, m_ipc;
   logic        m_req, m_kill, m_valid;
   int          m_ph;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .pc_next_i     (pc_next_i),
      .redirect_i    (redirect_i),
      .stall_i       (stall_i),
      .pc_o          (pc_o),
      .pc_plus_o     (pc_plus_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      .misalign_o    (misalign_o),
`endif
      .dec_ready_i   (dec_ready_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] loaded(input logic [31:0] v);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      return v;
`else
      return {v[31:2], 2'b00};
`endif
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
      m_req = 1'b0; m_kill = 1'b0; m_valid = 1'b0; m_ph = PH_IDLE;
   endtask

   // One clock of the fetch rules; redirect handled first, then normal progress.
   task automatic model_next(input logic rd, input logic [31:0] nx, input logic st,
                             input logic rdy, input logic rv, input logic [31:0] rdat,
                             input logic dr);
      logic hs, bad, entered_trap;
      hs  = m_req && rdy;
      bad = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      bad = (nx[1:0] != 2'b00);
`endif
      entered_trap = 1'b0;
      if (rd) begin
         m_pc = loaded(nx);
         if (m_ph == PH_IDLE) begin
            if (!st) begin m_ph = PH_REQ; m_req = 1'b1; end
         end else if (m_ph == PH_REQ) begin
            if (hs) begin m_ph = PH_WAIT; m_kill = 1'b1; end
            m_req = 1'b0;
         end else if (m_ph == PH_WAIT) begin
            if (rv) begin m_ph = PH_REQ; m_kill = 1'b0; m_req = !st; end
            else m_kill = 1'b1;
         end else if (m_ph == PH_HOLD) begin
            m_valid = 1'b0; m_ph = PH_REQ; m_req = !st;
         end else if (m_ph == PH_TRAP && !bad) begin
            m_ph = PH_REQ; m_req = !st;
         end
         entered_trap = bad;
      end else begin
         if (m_ph == PH_IDLE && !st) begin
            m_ph = PH_REQ; m_req = 1'b1;
         end else if (m_ph == PH_REQ) begin
            if (hs) begin m_ph = PH_WAIT; m_req = 1'b0; end
            else if (!st) m_req = 1'b1;
         end else if (m_ph == PH_WAIT && rv) begin
            if (m_kill) begin
               m_kill = 1'b0; m_ph = PH_REQ; m_req = !st;
            end else begin
               m_instr = rdat; m_ipc = m_pc; m_valid = 1'b1; m_ph = PH_HOLD;
            end
         end else if (m_ph == PH_HOLD && dr && !st) begin
            m_valid = 1'b0; m_pc = loaded(nx); m_ph = PH_REQ; m_req = 1'b1;
            entered_trap = bad;
         end
      end
      if (entered_trap) begin
         m_ph = PH_TRAP; m_req = 1'b0; m_kill = 1'b0; m_valid = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("pc", pc_o, m_pc);
      chk("pc_plus", pc_plus_o, m_pc + 32'd4);
      chk("req", 32'(imem_req_o), 32'(m_req));
      chk("addr", imem_addr_o, m_pc);
      chk("valid", 32'(instr_valid_o), 32'(m_valid));
      chk("instr", instr_o, m_instr);
      chk("instr_pc", instr_pc_o, m_ipc);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      chk("misalign", 32'(misalign_o), 32'(m_ph == PH_TRAP));
`endif
   endtask

   task automatic cycle(input logic rd, input logic [31:0] nx, input logic st,
                        input logic rdy, input logic rv, input logic [31:0] rdat,
                        input logic dr);
      redirect_i = rd; pc_next_i = nx; stall_i = st; imem_ready_i = rdy;
      imem_rvalid_i = rv; imem_rdata_i = rdat; dec_ready_i = dr;
      model_next(rd, nx, st, rdy, rv, rdat, dr);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      reset = 1'b1; redirect_i = 1'b0; pc_next_i = 32'h0; stall_i = 1'b0;
      imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; dec_ready_i = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      chk("rst_instr_nop", instr_o, 32'h0000_0013);
      reset = 1'b0;

      // Straight-line fetch: 0x0, 0x4, 0x8.
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("first_req", 32'(imem_req_o), 32'd1);
      chk("first_addr", imem_addr_o, 32'h0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b1);
      chk("first_instr", instr_o, 32'h0050_0093);
      chk("first_ipc", instr_pc_o, 32'h0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("second_addr", imem_addr_o, 32'h4);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b1);
      chk("second_ipc", instr_pc_o, 32'h4);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("third_addr", imem_addr_o, 32'h8);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      // Asynchronous reset while waiting for a response.
      #2 reset = 1'b1;
      #1;
      chk("arst_pc", pc_o, 32'h0);
      chk("arst_req", 32'(imem_req_o), 32'd0);
      chk("arst_valid", 32'(instr_valid_o), 32'd0);
      chk("arst_instr", instr_o, 32'h0000_0013);
      chk("arst_ipc", instr_pc_o, 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      check_all();
      cycle(1'b0, m_pc + 32'd4, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      chk("stray_rvalid_idle", 32'(instr_valid_o), 32'd0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      chk("stray_rvalid_req", 32'(instr_valid_o), 32'd0);

      // Redirect while waiting: the response is squashed.
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk("squash_valid", 32'(instr_valid_o), 32'd0);
      chk("squash_req", 32'(imem_req_o), 32'd1);
      chk("squash_addr", imem_addr_o, 32'h0000_0100);

      // Decode back-pressure and stall in HOLD.
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, m_pc + 32'd4, (i >= 3), 1'b1, 1'b0, 32'h0, (i >= 3));
         chk("hold_instr", instr_o, 32'h1234_5678);
         chk("hold_noreq", 32'(imem_req_o), 32'd0);
      end
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("hold_release_addr", imem_addr_o, 32'h0000_0104);

      // Redirect before handshake, then wrap-around of the sequential PC.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("redir_drop_req", 32'(imem_req_o), 32'd0);
      chk("wrap_pc_plus", pc_plus_o, 32'h0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("redir_reassert", 32'(imem_req_o), 32'd1);
      chk("redir_addr", imem_addr_o, 32'hFFFF_FFFC);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 1'b0);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("wrap_addr", imem_addr_o, 32'h0);
`ifndef PC_FETCH_MISALIGN_TRAP_EN
      cycle(1'b1, 32'h0000_0203, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("mask_low_bits", pc_o, 32'h0000_0200);
`endif

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic        rd;
         logic [31:0] nx;
         rd = ($urandom_range(7) == 0);
         nx = rd ? ($urandom() & 32'hFFFF_FFFC) : (m_pc + 32'd4);
`ifndef PC_FETCH_MISALIGN_TRAP_EN
         if ($urandom_range(3) == 0) nx[1:0] = 2'($urandom_range(3));
`endif
         cycle(rd, nx, ($urandom_range(3) == 0), ($urandom_range(1) == 1),
               ($urandom_range(1) == 1), $urandom(), ($urandom_range(1) == 1));
      end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
      cycle(1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("trap_flag", 32'(misalign_o), 32'd1);
      chk("trap_noreq", 32'(imem_req_o), 32'd0);
      chk("trap_pc", pc_o, 32'h0000_0102);
      cycle(1'b0, m_pc + 32'd4, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
      chk("trap_stays", 32'(misalign_o), 32'd1);
      cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("trap_exit_flag", 32'(misalign_o), 32'd0);
      chk("trap_exit_req", 32'(imem_req_o), 32'd1);
      chk("trap_exit_addr", imem_addr_o, 32'h0000_0200);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
